alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Instruction buffer and issue stage directly upstream of the 4-stage pipelined ALU.
//  Accepts 24-bit ALU instruction words over a valid/ready handshake.
//  Buffers them in a FIFO and drives rs1/rs2/rd/func/addr to the ALU, at most one per cycle.
//  Inserts harmless bubbles on read-after-write hazards against the ALU's regbank write-back.
// PARAMETERS
//  DEPTH        8      FIFO entries, power of 2, >=2
//  HAZ_WIN      2      number of previous issue slots checked for RAW hazards (1..4)
//  BUBBLE_REG   4'hF   scratch register used by bubble encoding; reserved, not checked
//  BUBBLE_ADDR  8'hFF  scratch memory address written by bubbles
// PORTS
//  clk          in   1   single clock; same net as ALU clk1; all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   instruction word present
//  in_ready     out  1   FIFO can accept: count<DEPTH and !flush
//  in_instr     in   24  {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}
//  flush        in   1   discard all buffered instructions
//  rs1,rs2,rd   out  4   to ALU, registered
//  func         out  4   to ALU, registered
//  addr         out  8   to ALU, registered
//  issue_valid  out  1   1 = outputs carry a real instruction this cycle; 0 = bubble
//  err_illegal  out  1   1-cycle pulse: head had func>=12, discarded
//  empty        out  1   FIFO count==0
// BEHAVIOUR
//  Reset (async): FIFO empty; scoreboard cleared; issue_valid=0, err_illegal=0.
//    Outputs take the bubble encoding. in_ready=1 once rst_n deasserts.
//  Bubble encoding: func=3 (SELA), rs1=rs2=rd=BUBBLE_REG, addr=BUBBLE_ADDR.
//    The ALU rewrites scratch reg/mem with unchanged-reg data.
//  Push when in_valid&&in_ready. When full, in_ready=0 even if a pop occurs the same cycle.
//  Latency: word pushed at edge N into an empty FIFO, no hazard -> driven on outputs after edge N+1.
//  Operand use by func:
//    A only: 3,8,10,11
//    B only: 4,9
//    A and B: 0,1,2,5,6,7
//  Hazard: scoreboard shift register of the last HAZ_WIN issue slots, holding {valid,rd}.
//    Bubbles enter with valid=0.
//    Head stalls if any used source (rs1 and/or rs2) equals a valid entry's rd.
//    On stall: bubble driven, head retained, scoreboard shifts (ages) every cycle.
//  Illegal head (func 12..15): popped without issue, err_illegal=1 for that cycle, bubble driven.
//    It is checked before hazard.
//  Empty FIFO: bubble every cycle.
//  flush: FIFO cleared at that edge; any push in the same cycle is dropped (in_ready=0).
//    Output register and scoreboard are unaffected; in-flight work completes.
//  Reset mid-operation: buffered instructions lost; no partial instruction is ever driven.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
// CONFIGURATION
//  ALU_ISSUE_STATS_EN defined adds outputs:
//    issue_cnt[15:0] increments per issued instruction.
//    stall_cnt[15:0] increments per hazard-stall cycle.
//    Both are reset to 0 and saturate at 16'hFFFF.
//  Not defined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  Reset mid-run with 3 words buffered -> empty=1.
//    Outputs equal bubble (func=3, rd=15, addr=FF) and issue_valid=0 asynchronously.
//  Push ADD r1=r2+r3, then SUB r4=r5-r6 back-to-back -> issued on consecutive cycles, no bubble.
//  Push ADD rd=1, then OR rs1=1 (HAZ_WIN=2) -> OR issues 3 cycles after ADD, with 2 bubbles between.
//  Push NEGB rs2=7 following rd=7 -> stall.
//    NEGA rs1=7,rs2=7 following rd=7 -> also stalls.
//    NEGA rs1=2,rs2=7 following rd=7 -> no stall (rs2 unused).
//  Fill 8 words with no pops -> in_ready=0.
//    flush with in_valid=1 -> empty=1 next cycle; the pushed word is never issued.
//  Head func=13 -> err_illegal one cycle, no issue_valid.
//    The next legal word issues the following cycle.
//    With ALU_ISSUE_STATS_EN, issue_cnt is unchanged by the illegal word.

Source files
------------

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//   Instruction buffer and issue stage feeding the 4-stage pipelined ALU.
//   Accepts 24-bit instruction words {func, rs1, rs2, rd, addr} over a
//   valid/ready handshake and holds them in a DEPTH-entry FIFO. It issues at
//   most one instruction per cycle on registered outputs. A scoreboard of the
//   last HAZ_WIN issue slots delays any head whose source registers are still
//   being written back; while it waits, a harmless bubble is driven.
//
//   Bubble encoding: func=3 (SELA), rs1=rs2=rd=BUBBLE_REG, addr=BUBBLE_ADDR.
//   The ALU just rewrites the scratch register/memory with unchanged data.
//
// Optional feature (macro ALU_ISSUE_STATS_EN):
//   adds issue_cnt / stall_cnt saturating 16-bit counters.
//
// Ports
//   clk          in   clock, all state on posedge (same net as ALU clk1)
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   instruction word present
//   in_ready     out  FIFO can accept (not full and no flush)
//   in_instr     in   {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}
//   flush        in   discard every buffered instruction
//   rs1,rs2,rd   out  register operands to ALU (registered)
//   func         out  ALU function (registered)
//   addr         out  memory address to ALU (registered)
//   issue_valid  out  1 = real instruction on the outputs, 0 = bubble
//   err_illegal  out  one-cycle pulse: head had func >= 12 and was dropped
//   empty        out  FIFO holds no instruction
//   issue_cnt    out  (ALU_ISSUE_STATS_EN) issued instruction count
//   stall_cnt    out  (ALU_ISSUE_STATS_EN) hazard stall cycle count
// -----------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int         DEPTH       = 8,
    parameter int         HAZ_WIN     = 2,
    parameter logic [3:0] BUBBLE_REG  = 4'hF,
    parameter logic [7:0] BUBBLE_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    input  logic        flush,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic        err_illegal,
    output logic        empty
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [3:0]       FUNC_SELA = 4'd3;

    // Operand usage per ALU function code.
    function automatic logic uses_a(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd10, 4'd11: uses_a = 1'b1;
            default:            uses_a = 1'b0;
        endcase
    endfunction

    function automatic logic uses_b(input logic [3:0] f);
        case (f)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9: uses_b = 1'b1;
            default:                                       uses_b = 1'b0;
        endcase
    endfunction

    logic [23:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Scoreboard: slot 0 is the most recent issue slot.
    logic [HAZ_WIN-1:0] r_sb_vld;
    logic [3:0]         r_sb_rd [HAZ_WIN];

    logic [23:0] w_head;
    logic [3:0]  w_hfunc, w_hrs1, w_hrs2, w_hrd;
    logic [7:0]  w_haddr;
    logic        w_push, w_pop;
    logic        w_head_vld, w_illegal, w_raw, w_stall, w_issue;

    assign empty    = (r_count == '0);
    // Depends only on stored count, so a same-cycle pop never reopens a full FIFO.
    assign in_ready = (r_count != FULL_CNT) && !flush;
    assign w_push   = in_valid && in_ready;

    assign w_head  = r_mem[r_rptr];
    assign w_hfunc = w_head[23:20];
    assign w_hrs1  = w_head[19:16];
    assign w_hrs2  = w_head[15:12];
    assign w_hrd   = w_head[11:8];
    assign w_haddr = w_head[7:0];

    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (r_sb_vld[i] &&
                ((uses_a(w_hfunc) && (w_hrs1 == r_sb_rd[i])) ||
                 (uses_b(w_hfunc) && (w_hrs2 == r_sb_rd[i]))))
                w_raw = 1'b1;
        end
    end

    // A flush discards the head along with everything behind it.
    assign w_head_vld = !empty && !flush;
    // Illegal check has priority over the hazard check.
    assign w_illegal  = w_head_vld && (w_hfunc >= 4'd12);
    assign w_stall    = w_head_vld && !w_illegal && w_raw;
    assign w_issue    = w_head_vld && !w_illegal && !w_stall;
    assign w_pop      = w_illegal || w_issue;

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= in_instr;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Scoreboard ages every cycle; bubbles enter as invalid slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HAZ_WIN; i++) begin
                r_sb_vld[i] <= 1'b0;
                r_sb_rd[i]  <= BUBBLE_REG;
            end
        end else begin
            r_sb_vld[0] <= w_issue;
            r_sb_rd[0]  <= w_issue ? w_hrd : BUBBLE_REG;
            for (int i = 1; i < HAZ_WIN; i++) begin
                r_sb_vld[i] <= r_sb_vld[i-1];
                r_sb_rd[i]  <= r_sb_rd[i-1];
            end
        end
    end

    // Issue output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func        <= FUNC_SELA;
            rs1         <= BUBBLE_REG;
            rs2         <= BUBBLE_REG;
            rd          <= BUBBLE_REG;
            addr        <= BUBBLE_ADDR;
            issue_valid <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            issue_valid <= w_issue;
            err_illegal <= w_illegal;
            if (w_issue) begin
                func <= w_hfunc;
                rs1  <= w_hrs1;
                rs2  <= w_hrs2;
                rd   <= w_hrd;
                addr <= w_haddr;
            end else begin
                func <= FUNC_SELA;
                rs1  <= BUBBLE_REG;
                rs2  <= BUBBLE_REG;
                rd   <= BUBBLE_REG;
                addr <= BUBBLE_ADDR;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_issue && (issue_cnt != 16'hFFFF))
                issue_cnt <= issue_cnt + 16'd1;
            if (w_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_queue
//   Directed bench for alu_issue_queue: reset state, back-to-back issue,
//   RAW stalls per operand usage, illegal head, fill/flush, mid-run reset.
// -----------------------------------------------------------------------------
module tb_alu_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic        flush;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        err_illegal;
    logic        empty;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
`endif

    int tests;
    int fails;

    alu_issue_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .issue_valid (issue_valid),
        .err_illegal (err_illegal),
        .empty       (empty)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Push w0 then w1 back-to-back; w0 issues one edge after its push.
    // If stall=1, w1 waits two bubbles (HAZ_WIN=2) before issuing.
    task automatic pair(input string tag, input logic [23:0] w0,
                        input logic [23:0] w1, input logic stall);
        in_valid = 1'b1;
        in_instr = w0;
        tick();
        chk({tag, "_push_bubble"}, 32'(issue_valid), 32'd0);
        in_instr = w1;
        tick();
        chk({tag, "_w0_valid"}, 32'(issue_valid), 32'd1);
        chk({tag, "_w0_fields"}, 32'({func, rs1, rs2, rd, addr}), 32'(w0));
        in_valid = 1'b0;
        tick();
        if (stall) begin
            chk({tag, "_stall1"}, 32'(issue_valid), 32'd0);
            chk({tag, "_stall1_func"}, 32'({func, rd, addr}), 32'h3F_FF);
            tick();
            chk({tag, "_stall2"}, 32'(issue_valid), 32'd0);
            tick();
        end
        chk({tag, "_w1_valid"}, 32'(issue_valid), 32'd1);
        chk({tag, "_w1_fields"}, 32'({func, rs1, rs2, rd, addr}), 32'(w1));
        idle(3);
    endtask

    initial begin
        logic full;
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_instr = 24'h0;
        flush    = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_bubble", 32'({func, rs1, rs2, rd, addr}), 32'h3FFF_FF);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // ADD r1=r2+r3 then SUB r4=r5-r6: no hazard, consecutive issue
        pair("addsub", 24'h0231_10, 24'h1564_20, 1'b0);
        // ADD rd=1 then two-operand op reading r1: two bubbles
        pair("raw_a", 24'h0231_00, 24'h6145_00, 1'b1);
        // NEGB (B only) rs2=7 after rd=7: stall
        pair("negb", 24'h0237_00, 24'h9271_00, 1'b1);
        // NEGA rs1=7 rs2=7 after rd=7: stall
        pair("nega77", 24'h0237_00, 24'h8771_00, 1'b1);
        // NEGA rs1=2 rs2=7 after rd=7: rs2 unused, no stall
        pair("nega27", 24'h0237_00, 24'h8271_00, 1'b0);

        // Illegal head func=13 followed by a legal word
        in_valid = 1'b1;
        in_instr = 24'hD123_00;
        tick();
        in_instr = 24'h0231_AA;
        tick();
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_no_issue", 32'(issue_valid), 32'd0);
`ifdef ALU_ISSUE_STATS_EN
        chk("ill_issue_cnt", 32'(issue_cnt), 32'd10);
`endif
        in_valid = 1'b0;
        tick();
        chk("ill_err_clear", 32'(err_illegal), 32'd0);
        chk("ill_next_valid", 32'(issue_valid), 32'd1);
        chk("ill_next_fields", 32'({func, rs1, rs2, rd, addr}), 32'h0231_AA);
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_issue_cnt", 32'(issue_cnt), 32'd11);
        chk("stat_stall_cnt", 32'(stall_cnt), 32'd6);
`endif
        idle(3);

        // Fill with a self-dependent chain until the FIFO reports full
        full     = 1'b0;
        in_valid = 1'b1;
        in_instr = 24'h0111_00;
        for (int i = 0; i < 40 && !full; i++) begin
            tick();
            if (!in_ready) full = 1'b1;
        end
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_not_empty", 32'(empty), 32'd0);

        // Flush with a push attempt in the same cycle
        flush    = 1'b1;
        in_instr = 24'h0239_5A;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_no_issue", 32'(issue_valid), 32'd0);
        end

        // Mid-run reset with 3 words buffered and an instruction on the outputs
        in_valid = 1'b1;
        in_instr = 24'h0231_00;
        tick();
        in_instr = 24'h0112_00;
        tick();
        in_instr = 24'h0113_00;
        tick();
        in_instr = 24'h0114_00;
        tick();
        in_instr = 24'h0115_00;
        tick();
        in_valid = 1'b0;
        chk("mid_issue_before", 32'({issue_valid, func, rd}), 32'h1_02);
        chk("mid_not_empty", 32'(empty), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_valid", 32'(issue_valid), 32'd0);
        chk("mid_rst_bubble", 32'({func, rs1, rs2, rd, addr}), 32'h3FFF_FF);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'({issue_valid, empty}), 32'b01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
